// File: rtl/rgmii_tx_if.sv
// RGMII transmit interface: GMII bytes at clk to 4-bit DDR pins for 1000/100/10 Mb/s,
// including the MAC byte-pacing strobe and a generic DDR output stage.

module rgmii_ddr_out #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d1,
    input  logic [W-1:0] i_d2,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q1;
    logic [W-1:0] r_q2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d1;
            r_q2 <= i_d2;
        end
    end

    // Clock-high half shows d1, clock-low half shows d2.
    assign o_q = i_clk ? r_q1 : r_q2;

endmodule

// mode      | meaning
// MODE_1000 | byte every clk, nibbles on both clk edges
// MODE_100  | byte every 2*TXC_DIV_100 clk, nibble held per txc period
// MODE_10   | byte every 2*TXC_DIV_10 clk, nibble held per txc period
module rgmii_tx_if #(
    parameter int TXC_DIV_100 = 5,
    parameter int TXC_DIV_10  = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic [7:0] gmii_txd,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    output logic       gmii_tx_clk_en,
    output logic       rgmii_txc,
    output logic [3:0] rgmii_txd,
    output logic       rgmii_tx_ctl
);

    localparam int DIV_MAX = (TXC_DIV_10 > TXC_DIV_100) ? TXC_DIV_10 : TXC_DIV_100;
    localparam int CNT_W   = $clog2(2 * DIV_MAX);

    localparam logic [1:0] MODE_1000 = 2'd0;
    localparam logic [1:0] MODE_100  = 2'd1;
    localparam logic [1:0] MODE_10   = 2'd2;

    logic             r_run;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_cnt;

    logic [7:0]       r_byte;
    logic             r_en;
    logic             r_er;
    logic             r_act;
    logic [1:0]       r_mode_d;
    logic [CNT_W-1:0] r_cnt_d;

    logic [1:0]       w_mode_req;
    logic [CNT_W-1:0] w_cnt_last;
    logic             w_boundary;
    logic [CNT_W-1:0] w_div_d;
    logic             w_second;
    logic [CNT_W-1:0] w_ph;
    logic [CNT_W-1:0] w_half;
    logic             w_txc_hi;
    logic             w_txc_lo;
    logic [3:0]       w_nib;
    logic [5:0]       w_d1;
    logic [5:0]       w_d2;
    logic [5:0]       w_pins;

    always_comb begin
        w_mode_req = MODE_1000;
        if (speed == 2'b01)
            w_mode_req = MODE_100;
        else if (speed == 2'b00)
            w_mode_req = MODE_10;
    end

    always_comb begin
        w_cnt_last = '0;
        case (r_mode)
            MODE_100: w_cnt_last = CNT_W'(2 * TXC_DIV_100 - 1);
            MODE_10:  w_cnt_last = CNT_W'(2 * TXC_DIV_10 - 1);
            default:  w_cnt_last = '0;
        endcase
    end

    // Speed is only adopted where a byte ends, so a nibble pair is never cut short.
    assign w_boundary = !r_run || (r_mode == MODE_1000) || (r_cnt == w_cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= 1'b0;
            r_mode <= MODE_1000;
            r_cnt  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_boundary) begin
                r_mode <= w_mode_req;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign gmii_tx_clk_en = r_run && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte   <= '0;
            r_en     <= 1'b0;
            r_er     <= 1'b0;
            r_act    <= 1'b0;
            r_mode_d <= MODE_1000;
            r_cnt_d  <= '0;
        end else begin
            if (gmii_tx_clk_en) begin
                r_byte <= gmii_txd;
                r_en   <= gmii_tx_en;
                r_er   <= gmii_tx_er;
            end
            r_act    <= r_run;
            r_mode_d <= r_mode;
            r_cnt_d  <= r_cnt;
        end
    end

    always_comb begin
        w_div_d = '0;
        case (r_mode_d)
            MODE_100: w_div_d = CNT_W'(TXC_DIV_100);
            MODE_10:  w_div_d = CNT_W'(TXC_DIV_10);
            default:  w_div_d = '0;
        endcase
    end

    assign w_second = (r_cnt_d >= w_div_d);
    assign w_ph     = w_second ? (r_cnt_d - w_div_d) : r_cnt_d;
    assign w_half   = w_div_d >> 1;
    // Odd divider: the middle cycle is high for its first half only.
    assign w_txc_hi = (w_ph < w_half) || (w_div_d[0] && (w_ph == w_half));
    assign w_txc_lo = (w_ph < w_half);
    assign w_nib    = w_second ? r_byte[7:4] : r_byte[3:0];

    always_comb begin
        w_d1 = '0;
        w_d2 = '0;
        if (r_act) begin
            if (r_mode_d == MODE_1000) begin
                w_d1 = {1'b1, r_byte[3:0], r_en};
                w_d2 = {1'b0, r_byte[7:4], r_en ^ r_er};
            end else begin
                w_d1 = {w_txc_hi, w_nib, w_txc_hi ? r_en : (r_en ^ r_er)};
                w_d2 = {w_txc_lo, w_nib, w_txc_lo ? r_en : (r_en ^ r_er)};
            end
        end
    end

    rgmii_ddr_out #(.W(6)) u_ddr (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d1    (w_d1),
        .i_d2    (w_d2),
        .o_q     (w_pins)
    );

    assign rgmii_txc    = w_pins[5];
    assign rgmii_txd    = w_pins[4:1];
    assign rgmii_tx_ctl = w_pins[0];

endmodule

// File: tb/tb_rgmii_tx_if.sv
// Directed bench for rgmii_tx_if: each task drives a scenario and compares DDR pin
// halves and the clock-enable strobe against hand-derived values.

module tb_rgmii_tx_if;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] speed;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       gmii_tx_clk_en;
    logic       rgmii_txc;
    logic [3:0] rgmii_txd;
    logic       rgmii_tx_ctl;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] s_hi;
    logic [5:0] s_lo;
    logic       s_en;

    always #5 clk = ~clk;

    rgmii_tx_if #(.TXC_DIV_100(5), .TXC_DIV_10(50)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .speed          (speed),
        .gmii_txd       (gmii_txd),
        .gmii_tx_en     (gmii_tx_en),
        .gmii_tx_er     (gmii_tx_er),
        .gmii_tx_clk_en (gmii_tx_clk_en),
        .rgmii_txc      (rgmii_txc),
        .rgmii_txd      (rgmii_txd),
        .rgmii_tx_ctl   (rgmii_tx_ctl)
    );

    task automatic drive(input logic [7:0] b, input logic e, input logic r);
        gmii_txd   = b;
        gmii_tx_en = e;
        gmii_tx_er = r;
    endtask

    // One clk cycle: strobe and high half sampled after posedge, low half after negedge.
    task automatic step();
        @(posedge clk);
        #2;
        s_en = gmii_tx_clk_en;
        s_hi = {rgmii_txc, rgmii_txd, rgmii_tx_ctl};
        @(negedge clk);
        #2;
        s_lo = {rgmii_txc, rgmii_txd, rgmii_tx_ctl};
    endtask

    task automatic do_reset(input logic [1:0] spd);
        rst_n = 1'b0;
        speed = spd;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        speed = 2'b10;
        drive(8'hFF, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if ({rgmii_txc, rgmii_txd, rgmii_tx_ctl} !== 6'h00) begin
            n_errors++;
            $display("FAIL reset_pins_hi got=%h exp=00", {rgmii_txc, rgmii_txd, rgmii_tx_ctl});
        end
        n_checks++;
        if (gmii_tx_clk_en !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_clk_en got=%b exp=0", gmii_tx_clk_en);
        end
        @(negedge clk);
        #2;
        n_checks++;
        if ({rgmii_txc, rgmii_txd, rgmii_tx_ctl} !== 6'h00) begin
            n_errors++;
            $display("FAIL reset_pins_lo got=%h exp=00", {rgmii_txc, rgmii_txd, rgmii_tx_ctl});
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (gmii_tx_clk_en !== 1'b0) begin
            n_errors++;
            $display("FAIL release_before_edge_clk_en got=%b exp=0", gmii_tx_clk_en);
        end
        step();
        n_checks++;
        if (s_en !== 1'b1) begin
            n_errors++;
            $display("FAIL first_clk_en got=%b exp=1", s_en);
        end
        step();
        n_checks++;
        if ({s_hi, s_lo} !== 12'h000) begin
            n_errors++;
            $display("FAIL release_no_partial got=%h exp=000", {s_hi, s_lo});
        end
    endtask

    task automatic test_1000();
        logic [11:0] exp [6];
        exp[0] = {1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        exp[1] = {1'b1, 4'h5, 1'b1, 1'b0, 4'h5, 1'b1};
        exp[2] = {1'b1, 4'h5, 1'b1, 1'b0, 4'h5, 1'b1};
        exp[3] = {1'b1, 4'h5, 1'b1, 1'b0, 4'hD, 1'b1};
        exp[4] = {1'b1, 4'h3, 1'b1, 1'b0, 4'hA, 1'b0};
        exp[5] = {1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 1'b1};
        drive(8'h00, 1'b0, 1'b0);
        repeat (2) step();
        drive(8'h55, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step();
            n_checks++;
            if (s_en !== 1'b1) begin
                n_errors++;
                $display("FAIL g1000_clk_en cyc=%0d got=%b exp=1", k, s_en);
            end
            n_checks++;
            if ({s_hi, s_lo} !== exp[(k == 6) ? 0 : k]) begin
                n_errors++;
                $display("FAIL g1000_pins cyc=%0d got=%h exp=%h", k, {s_hi, s_lo}, exp[(k == 6) ? 0 : k]);
            end
            case (k)
                0: drive(8'h55, 1'b1, 1'b0);
                1: drive(8'hD5, 1'b1, 1'b0);
                2: drive(8'hA3, 1'b1, 1'b1);
                3: drive(8'h0F, 1'b0, 1'b1);
                4: drive(8'h00, 1'b0, 1'b0);
                default: ;
            endcase
        end
    endtask

    task automatic test_100m();
        logic [3:0] nib_tab [4];
        nib_tab[0] = 4'hC;
        nib_tab[1] = 4'h3;
        nib_tab[2] = 4'hA;
        nib_tab[3] = 4'h5;
        drive(8'h3C, 1'b1, 1'b0);
        do_reset(2'b01);
        for (int k = 0; k < 22; k++) begin
            logic [11:0] e;
            logic [3:0]  nb;
            logic        th;
            logic        tl;
            int          j;
            int          p;
            step();
            n_checks++;
            if (s_en !== (k % 10 == 0)) begin
                n_errors++;
                $display("FAIL m100_clk_en cyc=%0d got=%b exp=%b", k, s_en, (k % 10 == 0));
            end
            if (k < 2) begin
                e = 12'h000;
            end else begin
                j  = k - 2;
                p  = j % 5;
                th = (p < 3);
                tl = (p < 2);
                nb = nib_tab[j / 5];
                e  = {th, nb, 1'b1, tl, nb, 1'b1};
            end
            n_checks++;
            if ({s_hi, s_lo} !== e) begin
                n_errors++;
                $display("FAIL m100_pins cyc=%0d got=%h exp=%h", k, {s_hi, s_lo}, e);
            end
            if (k == 10) drive(8'h5A, 1'b1, 1'b0);
        end
    endtask

    task automatic test_10m();
        int pulses;
        pulses = 0;
        drive(8'hE1, 1'b1, 1'b1);
        do_reset(2'b00);
        for (int k = 0; k < 202; k++) begin
            logic [11:0] e;
            logic [3:0]  nb;
            logic        th;
            int          j;
            step();
            if (s_en === 1'b1) pulses++;
            n_checks++;
            if (s_en !== (k % 100 == 0)) begin
                n_errors++;
                $display("FAIL m10_clk_en cyc=%0d got=%b exp=%b", k, s_en, (k % 100 == 0));
            end
            if (k < 2) begin
                e = 12'h000;
            end else begin
                j  = k - 2;
                th = ((j % 50) < 25);
                nb = (((j / 50) % 2) == 0) ? 4'h1 : 4'hE;
                e  = {th, nb, th, th, nb, th};
            end
            n_checks++;
            if ({s_hi, s_lo} !== e) begin
                n_errors++;
                $display("FAIL m10_pins cyc=%0d got=%h exp=%h", k, {s_hi, s_lo}, e);
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_errors++;
            $display("FAIL m10_pulse_count got=%0d exp=3", pulses);
        end
    endtask

    task automatic test_speed_change();
        drive(8'h3C, 1'b1, 1'b0);
        do_reset(2'b01);
        for (int k = 0; k < 26; k++) begin
            logic [11:0] e;
            logic [3:0]  nb;
            logic        ee;
            int          j;
            int          p;
            step();
            ee = (k == 0) || ((k >= 10) && (k <= 15)) || (k == 25);
            n_checks++;
            if (s_en !== ee) begin
                n_errors++;
                $display("FAIL spd_clk_en cyc=%0d got=%b exp=%b", k, s_en, ee);
            end
            if (k < 2) begin
                e = 12'h000;
            end else if (k <= 11 || k >= 17) begin
                j  = (k <= 11) ? (k - 2) : (k - 17);
                p  = j % 5;
                nb = (j < 5) ? 4'hC : 4'h3;
                e  = {(p < 3), nb, 1'b1, (p < 2), nb, 1'b1};
            end else if (k == 12) begin
                e = {1'b1, 4'h7, 1'b1, 1'b0, 4'h7, 1'b1};
            end else if (k == 16) begin
                e = {1'b1, 4'hC, 1'b1, 1'b0, 4'h3, 1'b1};
            end else begin
                e = {1'b1, 4'h8, 1'b1, 1'b0, 4'h8, 1'b1};
            end
            n_checks++;
            if ({s_hi, s_lo} !== e) begin
                n_errors++;
                $display("FAIL spd_pins cyc=%0d got=%h exp=%h", k, {s_hi, s_lo}, e);
            end
            case (k)
                4:  speed = 2'b10;
                10: drive(8'h77, 1'b1, 1'b0);
                11: drive(8'h88, 1'b1, 1'b0);
                14: begin
                    speed = 2'b01;
                    drive(8'h3C, 1'b1, 1'b0);
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid();
        drive(8'h3C, 1'b1, 1'b0);
        do_reset(2'b01);
        repeat (5) step();
        @(posedge clk);
        #3;
        n_checks++;
        if ({rgmii_txc, rgmii_txd, rgmii_tx_ctl} !== {1'b0, 4'hC, 1'b1}) begin
            n_errors++;
            $display("FAIL mid_pre_reset got=%h exp=%h", {rgmii_txc, rgmii_txd, rgmii_tx_ctl}, {1'b0, 4'hC, 1'b1});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gmii_tx_clk_en, rgmii_txc, rgmii_txd, rgmii_tx_ctl} !== 7'h00) begin
            n_errors++;
            $display("FAIL mid_async_clear got=%h exp=00", {gmii_tx_clk_en, rgmii_txc, rgmii_txd, rgmii_tx_ctl});
        end
        drive(8'h96, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        n_checks++;
        if ({rgmii_txc, rgmii_txd, rgmii_tx_ctl} !== 6'h00) begin
            n_errors++;
            $display("FAIL mid_held_low got=%h exp=00", {rgmii_txc, rgmii_txd, rgmii_tx_ctl});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [11:0] e;
            step();
            n_checks++;
            if (s_en !== (k == 0)) begin
                n_errors++;
                $display("FAIL mid_clk_en cyc=%0d got=%b exp=%b", k, s_en, (k == 0));
            end
            case (k)
                0, 1:    e = 12'h000;
                2:       e = {1'b1, 4'h6, 1'b1, 1'b1, 4'h6, 1'b1};
                3:       e = {1'b1, 4'h6, 1'b1, 1'b1, 4'h6, 1'b1};
                4:       e = {1'b1, 4'h6, 1'b1, 1'b0, 4'h6, 1'b1};
                5, 6:    e = {1'b0, 4'h6, 1'b1, 1'b0, 4'h6, 1'b1};
                default: e = {1'b1, 4'h9, 1'b1, 1'b1, 4'h9, 1'b1};
            endcase
            n_checks++;
            if ({s_hi, s_lo} !== e) begin
                n_errors++;
                $display("FAIL mid_pins cyc=%0d got=%h exp=%h", k, {s_hi, s_lo}, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        speed = 2'b10;
        drive(8'h00, 1'b0, 1'b0);
        test_reset();
        test_1000();
        test_100m();
        test_10m();
        test_speed_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
